// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch front-end: FSM states, entry/exception payloads, immediate decode.
// Static prediction (FETCH_STATIC_PREDICT_EN) uses imm_j/imm_b from here.
package fetch_pkg;

  localparam int unsigned XLEN = 64;
  localparam int unsigned ILEN = 32;

  typedef enum logic [2:0] {IDLE, REQ, WAIT, DRAIN, HALT} fetch_state_e;

  localparam logic [XLEN-1:0] INSTR_ADDR_MISALIGNED = 64'd0;
  localparam logic [XLEN-1:0] INSTR_ACCESS_FAULT    = 64'd1;
  localparam logic [XLEN-1:0] INSTR_PAGE_FAULT      = 64'd12;

  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] cause;
    logic [XLEN-1:0] tval;
  } ex_t;

  typedef struct packed {
    logic            valid;
    logic            taken;
    logic [XLEN-1:0] target;
  } predict_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] addr;
    logic [ILEN-1:0] instr;
    predict_t        predict;
    ex_t             ex;
  } fetch_entry_t;

  // Sign-extended J-type immediate (JAL offset)
  function automatic logic [XLEN-1:0] imm_j(input logic [ILEN-1:0] i);
    return {{43{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
  endfunction

  // Sign-extended B-type immediate (conditional branch offset)
  function automatic logic [XLEN-1:0] imm_b(input logic [ILEN-1:0] i);
    return {{51{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small power-of-two FIFO for fetch entries; flush clears it and wins over a same-cycle push.
module fetch_fifo #(
  parameter type         T     = logic,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  T                           data_i,
  input  logic                       pop_i,
  output T                           data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  T             mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] count;
  logic          push_ok;
  logic          pop_ok;

  assign full_o  = (count == CW'(DEPTH));
  assign empty_o = (count == '0);
  assign count_o = count;
  assign data_o  = mem[rptr];
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) wptr <= wptr + AW'(1);
      if (pop_ok)  rptr <= rptr + AW'(1);
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

  // Storage needs no reset; pointers define what is live
  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wptr] <= data_i;
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: PC, single-outstanding I-cache requests, entry queue towards decode.
// Optional static prediction of JAL / backward branches under FETCH_STATIC_PREDICT_EN.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter logic [63:0] BOOT_ADDR = 64'h8000_0000,
  parameter int unsigned FQ_DEPTH  = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         redirect_i,
  input  logic [63:0]  redirect_pc_i,
  output logic         icache_req_o,
  output logic [63:0]  icache_addr_o,
  input  logic         icache_gnt_i,
  input  logic         icache_rvalid_i,
  input  logic [31:0]  icache_rdata_i,
  input  ex_t          icache_ex_i,
  output fetch_entry_t fetch_o,
  input  logic         fetch_ready_i
);

  localparam int unsigned CW = $clog2(FQ_DEPTH) + 1;

  fetch_state_e  state;
  logic [63:0]   pc;
  logic [63:0]   next_pc;
  predict_t      pred;
  fetch_entry_t  push_entry;
  fetch_entry_t  head;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic          misaligned;
  logic          credit;
  logic          in_flight;

  assign misaligned = (pc[1:0] != 2'b00);
  assign credit     = (count < CW'(FQ_DEPTH));
  assign pop        = !empty && fetch_ready_i;

  // A response is still owed to us after this cycle
  assign in_flight = ((state == WAIT || state == DRAIN) && !icache_rvalid_i) ||
                     (state == REQ && icache_gnt_i);

`ifdef FETCH_STATIC_PREDICT_EN
  always_comb begin
    pred = '0;
    if (!icache_ex_i.valid) begin
      if (icache_rdata_i[6:0] == OPCODE_JAL) begin
        pred = '{valid: 1'b1, taken: 1'b1, target: pc + imm_j(icache_rdata_i)};
      end else if (icache_rdata_i[6:0] == OPCODE_BRANCH && icache_rdata_i[31]) begin
        pred = '{valid: 1'b1, taken: 1'b1, target: pc + imm_b(icache_rdata_i)};
      end
    end
  end
`else
  assign pred = '0;
`endif

  assign next_pc = pred.taken ? pred.target : pc + 64'd4;

  always_comb begin
    push_entry       = '0;
    push_entry.valid = 1'b1;
    push_entry.addr  = pc;
    if (state == IDLE) begin
      push_entry.ex = '{valid: 1'b1, cause: INSTR_ADDR_MISALIGNED, tval: pc};
    end else begin
      push_entry.instr   = icache_rdata_i;
      push_entry.predict = pred;
      push_entry.ex      = icache_ex_i;
    end
  end

  assign push = !redirect_i && !full &&
                ((state == IDLE && misaligned && credit) ||
                 (state == WAIT && icache_rvalid_i));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= IDLE;
      pc            <= BOOT_ADDR;
      icache_req_o  <= 1'b0;
      icache_addr_o <= BOOT_ADDR;
    end else if (redirect_i) begin
      pc           <= redirect_pc_i;
      icache_req_o <= 1'b0;
      state        <= in_flight ? DRAIN : IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (credit) begin
            if (misaligned) begin
              state <= HALT;
            end else begin
              icache_req_o  <= 1'b1;
              icache_addr_o <= {pc[63:2], 2'b00};
              state         <= REQ;
            end
          end
        end
        REQ: begin
          if (icache_gnt_i) begin
            icache_req_o <= 1'b0;
            state        <= WAIT;
          end
        end
        WAIT: begin
          if (icache_rvalid_i) begin
            pc    <= next_pc;
            state <= icache_ex_i.valid ? HALT : IDLE;
          end
        end
        DRAIN: begin
          if (icache_rvalid_i) state <= IDLE;
        end
        HALT: state <= HALT;
        default: state <= IDLE;
      endcase
    end
  end

  fetch_fifo #(
    .T     (fetch_entry_t),
    .DEPTH (FQ_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (redirect_i),
    .push_i  (push),
    .data_i  (push_entry),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  always_comb begin
    fetch_o       = head;
    fetch_o.valid = head.valid & ~empty;
  end

endmodule
